// File: rtl/xphy_reset_seq_if.sv
// Signal bundle between the reset sequencer and the PHY clocking path.
// Lock/done inputs are level signals from other clock domains; there is no valid/ready handshake here.
interface xphy_reset_seq_if;
  logic       qplllock_in;
  logic       mmcm_locked_in;
  logic       gt_resetdone_in;
  logic       qpll_reset;
  logic       gt_txreset;
  logic       gt_rxreset;
  logic       core_reset;
  logic       ready;
  logic [7:0] retry_count;
  logic [2:0] state;

  modport master (
    input  qplllock_in, mmcm_locked_in, gt_resetdone_in,
    output qpll_reset, gt_txreset, gt_rxreset, core_reset, ready, retry_count, state
  );

  modport slave (
    output qplllock_in, mmcm_locked_in, gt_resetdone_in,
    input  qpll_reset, gt_txreset, gt_rxreset, core_reset, ready, retry_count, state
  );
endinterface

// File: rtl/xphy_reset_seq.sv
// 10G PHY reset sequencer: QPLL reset, lock waits, GT reset pulse, settle, then core release.
// Lock loss or timeout restarts at QPLL_RST and bumps a saturating retry counter.
module xphy_reset_seq #(
  parameter int C_RST_CYCLES    = 16,
  parameter int C_LOCK_TIMEOUT  = 50000,
  parameter int C_SETTLE_CYCLES = 256
) (
  input logic               clk,
  input logic               rst,
  xphy_reset_seq_if.master  phy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_QPLL_RST  = 3'd1,
    S_WAIT_QPLL = 3'd2,
    S_WAIT_MMCM = 3'd3,
    S_GT_RST    = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_SETTLE    = 3'd6,
    S_RUN       = 3'd7
  } state_e;

  localparam logic [15:0] RST_LAST     = 16'(C_RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(C_LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(C_SETTLE_CYCLES - 1);

  // bit 0 = qpll lock, bit 1 = mmcm lock, bit 2 = gt reset-done
  logic [2:0]  meta_q, meta_d;
  logic [2:0]  sync_q, sync_d;
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  retry_q, retry_d;
  logic        restart;
  logic        qpll_ok, mmcm_ok, done_ok, lock_lost;

  always_comb begin
    meta_d = {phy.gt_resetdone_in, phy.mmcm_locked_in, phy.qplllock_in};
    sync_d = meta_q;
  end

  assign qpll_ok   = sync_q[0];
  assign mmcm_ok   = sync_q[1];
  assign done_ok   = sync_q[2];
  assign lock_lost = !qpll_ok || !mmcm_ok;

  // Priority in each wait state: lock loss, then success, then timeout.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    restart = 1'b0;
    case (state_q)
      S_IDLE:      state_d = S_QPLL_RST;
      S_QPLL_RST:  if (timer_q == RST_LAST) state_d = S_WAIT_QPLL;
      S_WAIT_QPLL: begin
        if (qpll_ok)                      state_d = S_WAIT_MMCM;
        else if (timer_q == TIMEOUT_LAST) restart = 1'b1;
      end
      S_WAIT_MMCM: begin
        if (!qpll_ok)                     restart = 1'b1;
        else if (mmcm_ok)                 state_d = S_GT_RST;
        else if (timer_q == TIMEOUT_LAST) restart = 1'b1;
      end
      S_GT_RST:    if (timer_q == RST_LAST) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (lock_lost)                    restart = 1'b1;
        else if (done_ok)                 state_d = S_SETTLE;
        else if (timer_q == TIMEOUT_LAST) restart = 1'b1;
      end
      S_SETTLE: begin
        if (lock_lost)                    restart = 1'b1;
        else if (timer_q == SETTLE_LAST)  state_d = S_RUN;
      end
      S_RUN:       if (lock_lost) restart = 1'b1;
      default:     state_d = S_IDLE;
    endcase
    if (restart) begin
      state_d = S_QPLL_RST;
      if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
    end
    timer_d = (state_d != state_q) ? 16'd0 : timer_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      state_q <= S_IDLE;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  assign phy.qpll_reset  = state_q inside {S_IDLE, S_QPLL_RST};
  assign phy.gt_txreset  = state_q inside {S_IDLE, S_QPLL_RST, S_WAIT_QPLL, S_WAIT_MMCM, S_GT_RST};
  assign phy.gt_rxreset  = state_q inside {S_IDLE, S_QPLL_RST, S_WAIT_QPLL, S_WAIT_MMCM, S_GT_RST};
  assign phy.core_reset  = (state_q != S_RUN);
  assign phy.ready       = (state_q == S_RUN);
  assign phy.retry_count = retry_q;
  assign phy.state       = state_q;

endmodule

// File: tb/tb_xphy_reset_seq.sv
// Bench for xphy_reset_seq: an elapsed-cycle reference model pushes every expected output change
// into a queue; a negedge monitor pops one entry per observed DUT change and compares.
`timescale 1ns/1ps
module tb_xphy_reset_seq;
  localparam int RST_C = 16;
  localparam int TO_C  = 100;
  localparam int SET_C = 256;
  localparam int W     = 48;
  localparam logic [15:0] RESET_VEC = 16'h001E;

  logic clk = 1'b0;
  logic rst = 1'b1;

  xphy_reset_seq_if phy_if ();

  xphy_reset_seq #(
    .C_RST_CYCLES(RST_C),
    .C_LOCK_TIMEOUT(TO_C),
    .C_SETTLE_CYCLES(SET_C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .phy(phy_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int   m_state = 0;
  int   m_enter = 0;
  int   m_retry = 0;
  logic [2:0]  dl1 = 3'b000;
  logic [2:0]  dl2 = 3'b000;
  logic [15:0] m_vec_prev = RESET_VEC;

  // Stages are ordered, so the output decode is a set of range tests on the stage number.
  function automatic logic [15:0] vec_of(int st, int rc);
    logic qr, gr, cr, rd;
    qr = (st <= 1);
    gr = (st <= 4);
    cr = (st != 7);
    rd = (st == 7);
    return {st[2:0], rc[7:0], qr, gr, gr, cr, rd};
  endfunction

  always @(posedge clk) begin : model
    logic [2:0]  seen;
    logic [15:0] v;
    int  nxt, el;
    bit  restart, q, m, d;
    cyc  = cyc + 1;
    seen = dl2;
    if (rst) begin
      m_state = 0; m_enter = cyc; m_retry = 0;
      dl1 = 3'b000; dl2 = 3'b000;
    end else begin
      q = seen[0]; m = seen[1]; d = seen[2];
      el = cyc - m_enter;
      nxt = m_state;
      restart = 1'b0;
      case (m_state)
        0: nxt = 1;
        1: if (el == RST_C) nxt = 2;
        2: if (q) nxt = 3; else if (el == TO_C) restart = 1'b1;
        3: if (!q) restart = 1'b1; else if (m) nxt = 4; else if (el == TO_C) restart = 1'b1;
        4: if (el == RST_C) nxt = 5;
        5: if (!q || !m) restart = 1'b1; else if (d) nxt = 6; else if (el == TO_C) restart = 1'b1;
        6: if (!q || !m) restart = 1'b1; else if (el == SET_C) nxt = 7;
        default: if (!q || !m) restart = 1'b1;
      endcase
      if (restart) begin
        nxt = 1;
        if (m_retry < 255) m_retry = m_retry + 1;
      end
      if (nxt != m_state) begin
        m_state = nxt;
        m_enter = cyc;
      end
      dl2 = dl1;
      dl1 = {phy_if.gt_resetdone_in, phy_if.mmcm_locked_in, phy_if.qplllock_in};
    end
    v = vec_of(m_state, m_retry);
    if (v != m_vec_prev) begin
      if (mon_en) exp_q.push_back({cyc[31:0], v});
      m_vec_prev = v;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [15:0] dut_prev = RESET_VEC;

  function automatic logic [15:0] dut_vec();
    return {phy_if.state, phy_if.retry_count, phy_if.qpll_reset, phy_if.gt_txreset,
            phy_if.gt_rxreset, phy_if.core_reset, phy_if.ready};
  endfunction

  always @(negedge clk) begin : monitor
    logic [15:0]  dv;
    logic [W-1:0] e;
    if (mon_en) begin
      dv = dut_vec();
      if (dv !== dut_prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errs++;
          $display("FAIL unexpected_change cyc=%0d got state=%0d retry=%0d outs=%b, required no change",
                   cyc, dv[15:13], dv[12:5], dv[4:0]);
        end else begin
          e = exp_q.pop_front();
          if (e !== {cyc[31:0], dv}) begin
            n_errs++;
            $display("FAIL transition got cyc=%0d state=%0d retry=%0d outs=%b, required cyc=%0d state=%0d retry=%0d outs=%b",
                     cyc, dv[15:13], dv[12:5], dv[4:0], e[47:16], e[15:13], e[12:5], e[4:0]);
          end
        end
        dut_prev = dv;
      end
      while (exp_q.size() > 0 && int'(exp_q[0][47:16]) < cyc) begin
        n_checks++;
        n_errs++;
        $display("FAIL missed_transition at cyc=%0d, required state=%0d retry=%0d at cyc=%0d",
                 cyc, exp_q[0][15:13], exp_q[0][12:5], exp_q[0][47:16]);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(bit q, bit m, bit d);
    phy_if.qplllock_in     = q;
    phy_if.mmcm_locked_in  = m;
    phy_if.gt_resetdone_in = d;
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s got=%0d required=%0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_state(int s, int budget, string tag);
    for (int i = 0; i < budget; i++) begin
      if (int'(phy_if.state) == s) begin
        n_checks++;
        return;
      end
      @(negedge clk);
    end
    n_checks++;
    n_errs++;
    $display("FAIL wait_%s got state=%0d required=%0d within %0d cycles", tag, phy_if.state, s, budget);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_state"}, int'(phy_if.state), 0);
    check({tag, "_qpll_reset"}, int'(phy_if.qpll_reset), 1);
    check({tag, "_gt_txreset"}, int'(phy_if.gt_txreset), 1);
    check({tag, "_gt_rxreset"}, int'(phy_if.gt_rxreset), 1);
    check({tag, "_core_reset"}, int'(phy_if.core_reset), 1);
    check({tag, "_ready"}, int'(phy_if.ready), 0);
    check({tag, "_retry"}, int'(phy_if.retry_count), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    set_in(0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
    step(3);
    check_reset_outputs("por");
    rst = 1'b0;

    // Nominal bring-up, with the synchronizer latency probed on the mmcm lock.
    wait_state(2, 40, "qpll_fall");
    step($urandom_range(5, 60));
    set_in(1, 0, 0);
    wait_state(3, 10, "wait_mmcm");
    step($urandom_range(3, 40));
    set_in(1, 1, 0);
    step(1);
    check("sync_edge_n", int'(phy_if.state), 3);
    step(1);
    check("sync_edge_n1", int'(phy_if.state), 3);
    step(1);
    check("sync_edge_n2", int'(phy_if.state), 4);
    check("gt_reset_pulse", int'(phy_if.gt_txreset), 1);
    wait_state(5, 40, "wait_done");
    step($urandom_range(1, 50));
    set_in(1, 1, 1);
    wait_state(7, 400, "run1");
    check("run1_ready", int'(phy_if.ready), 1);
    check("run1_core_reset", int'(phy_if.core_reset), 0);
    check("run1_retry", int'(phy_if.retry_count), 0);

    // One-cycle mmcm drop in RUN.
    step($urandom_range(5, 20));
    set_in(1, 0, 1);
    step(1);
    set_in(1, 1, 0);
    step(1);
    check("drop_n1_ready", int'(phy_if.ready), 1);
    step(1);
    check("drop_n2_ready", int'(phy_if.ready), 0);
    check("drop_n2_qpll_reset", int'(phy_if.qpll_reset), 1);
    check("drop_n2_retry", int'(phy_if.retry_count), 1);
    wait_state(5, 200, "redo_wait_done");
    step($urandom_range(1, 50));
    set_in(1, 1, 1);
    wait_state(7, 400, "run2");
    check("run2_retry", int'(phy_if.retry_count), 1);

    // QPLL glitch, then reset asserted during SETTLE.
    set_in(0, 1, 0);
    step($urandom_range(1, 4));
    set_in(1, 1, 0);
    wait_state(5, 200, "glitch_wait_done");
    set_in(1, 1, 1);
    wait_state(6, 20, "settle");
    step($urandom_range(5, 200));
    rst = 1'b1;
    step(1);
    check_reset_outputs("settle_rst");
    rst = 1'b0;
    step(1);
    check("after_rst_state", int'(phy_if.state), 1);
    wait_state(7, 600, "run3");
    check("run3_ready", int'(phy_if.ready), 1);

    // Random lock/done activity, checked entirely by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      logic q, m, d;
      q = phy_if.qplllock_in;
      m = phy_if.mmcm_locked_in;
      d = phy_if.gt_resetdone_in;
      q = q ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 19) == 0);
      m = m ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 19) == 0);
      d = d ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 29) == 0);
      set_in(q, m, d);
      step(1);
    end

    // No QPLL lock: periodic retries, then saturation of the counter.
    set_in(0, 0, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wait_state(1, 5, "to_qpll_rst");
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      while (int'(phy_if.retry_count) != k && n < 300) begin
        step(1);
        n++;
      end
      check("timeout_retry", int'(phy_if.retry_count), k);
      check("timeout_state", int'(phy_if.state), 1);
      if (k > 1) check("timeout_period", n, RST_C + TO_C);
    end
    step(300 * (RST_C + TO_C));
    check("retry_saturated", int'(phy_if.retry_count), 255);

    step(5);
    check("queue_drained", exp_q.size(), 0);
    check("final_vector", int'(dut_vec()), int'(m_vec_prev));
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
